// File: rtl/avalon_axil_master.sv
// -----------------------------------------------------------------------------
// avalon_axil_master
//
// Bridges the 16-bit local register bus (cs / read_n / write_n / address /
// writedata / readdata / waitrequest) to an AXI4-Lite master port. Each
// accepted local request becomes exactly one AXI4-Lite single transfer. The
// local side is stalled with waitrequest until the AXI response has returned.
//
// Ports
//   m_axi_aclk      clock, all logic on the rising edge
//   m_axi_aresetn   asynchronous active-low reset
//   address         local word address (5 bits)
//   writedata       local write data (16 bits)
//   readdata        read data, updated on read completion, held otherwise
//   cs              chip select, high active
//   read_n/write_n  active-low request strobes (write wins if both low)
//   waitrequest     high while a request is present and not yet accepted
//   resp_err        high if the last completed transfer returned RESP != OKAY
//   m_axi_aw*/w*/b* AXI4-Lite write channels
//   m_axi_ar*/r*    AXI4-Lite read channels
// -----------------------------------------------------------------------------
module avalon_axil_master #(
    parameter int AW = 8
) (
    input  logic          m_axi_aclk,
    input  logic          m_axi_aresetn,

    input  logic [4:0]    address,
    input  logic [15:0]   writedata,
    output logic [15:0]   readdata,
    input  logic          cs,
    input  logic          read_n,
    input  logic          write_n,
    output logic          waitrequest,
    output logic          resp_err,

    output logic [AW-1:0] m_axi_awaddr,
    output logic          m_axi_awvalid,
    input  logic          m_axi_awready,

    output logic [31:0]   m_axi_wdata,
    output logic [3:0]    m_axi_wstrb,
    output logic          m_axi_wvalid,
    input  logic          m_axi_wready,

    input  logic [1:0]    m_axi_bresp,
    input  logic          m_axi_bvalid,
    output logic          m_axi_bready,

    output logic [AW-1:0] m_axi_araddr,
    output logic          m_axi_arvalid,
    input  logic          m_axi_arready,

    input  logic [31:0]   m_axi_rdata,
    input  logic [1:0]    m_axi_rresp,
    input  logic          m_axi_rvalid,
    output logic          m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t         state_q, state_d;

    logic [AW-1:0]  awaddr_q, awaddr_d;
    logic [AW-1:0]  araddr_q, araddr_d;
    logic [15:0]    wdata_q, wdata_d;
    logic           awvalid_q, awvalid_d;
    logic           wvalid_q, wvalid_d;
    logic           bready_q, bready_d;
    logic           arvalid_q, arvalid_d;
    logic           rready_q, rready_d;
    logic           aw_done_q, aw_done_d;
    logic           w_done_q, w_done_d;
    logic [15:0]    readdata_q, readdata_d;
    logic           resp_err_q, resp_err_d;

    logic           wr_req;
    logic           rd_req;
    logic           any_req;
    logic [AW-1:0]  local_addr;
    logic           aw_hs;
    logic           w_hs;
    logic           b_hs;
    logic           ar_hs;
    logic           r_hs;

    // Only the low half of the AXI read data carries register content.
    logic           unused_rdata_hi;
    assign unused_rdata_hi = ^m_axi_rdata[31:16];

    // Write takes priority when both strobes are low.
    assign wr_req  = cs & ~write_n;
    assign rd_req  = cs & ~read_n & write_n;
    assign any_req = cs & (~write_n | ~read_n);

    // Local word address -> AXI byte address.
    assign local_addr = {{(AW-7){1'b0}}, address, 2'b00};

    assign aw_hs = awvalid_q & m_axi_awready;
    assign w_hs  = wvalid_q  & m_axi_wready;
    assign b_hs  = bready_q  & m_axi_bvalid;
    assign ar_hs = arvalid_q & m_axi_arready;
    assign r_hs  = rready_q  & m_axi_rvalid;

    // DONE is the single cycle in which a present request is accepted.
    assign waitrequest = any_req & (state_q != DONE);

    always_comb begin
        state_d    = state_q;
        awaddr_d   = awaddr_q;
        araddr_d   = araddr_q;
        wdata_d    = wdata_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        readdata_d = readdata_q;
        resp_err_d = resp_err_q;

        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d   = WR_REQ;
                    awaddr_d  = local_addr;
                    wdata_d   = writedata;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else if (rd_req) begin
                    state_d   = RD_REQ;
                    araddr_d  = local_addr;
                    arvalid_d = 1'b1;
                end
            end

            WR_REQ: begin
                // AW and W complete independently; the done flags remember
                // which one has already handshaken.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                    state_d   = WR_RESP;
                    bready_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end

            WR_RESP: begin
                if (b_hs) begin
                    bready_d   = 1'b0;
                    resp_err_d = |m_axi_bresp;
                    state_d    = DONE;
                end
            end

            RD_REQ: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end

            RD_RESP: begin
                if (r_hs) begin
                    rready_d   = 1'b0;
                    readdata_d = m_axi_rdata[15:0];
                    resp_err_d = |m_axi_rresp;
                    state_d    = DONE;
                end
            end

            DONE: begin
                // Any request still present here has just been accepted; a
                // new one is only looked at in IDLE.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q    <= IDLE;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            wdata_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            readdata_q <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            awaddr_q   <= awaddr_d;
            araddr_q   <= araddr_d;
            wdata_q    <= wdata_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            readdata_q <= readdata_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = {16'd0, wdata_q};
    assign m_axi_wstrb   = 4'b0011;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign readdata      = readdata_q;
    assign resp_err      = resp_err_q;

endmodule

// File: tb/tb_avalon_axil_master.sv
// -----------------------------------------------------------------------------
// tb_avalon_axil_master
//
// Directed bench for avalon_axil_master. The AXI slave side is driven by hand
// cycle by cycle. Each cycle: advance to 1 time unit after the rising edge,
// apply inputs, wait 1 more unit, then compare outputs.
// -----------------------------------------------------------------------------
module tb_avalon_axil_master;

    logic        clk;
    logic        rst_n;
    logic [4:0]  address;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        cs;
    logic        read_n;
    logic        write_n;
    logic        waitrequest;
    logic        resp_err;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int total  = 0;
    int passed = 0;
    int failed = 0;
    int hi_cnt = 0;

    avalon_axil_master #(.AW(8)) dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .cs            (cs),
        .read_n        (read_n),
        .write_n       (write_n),
        .waitrequest   (waitrequest),
        .resp_err      (resp_err),
        .m_axi_awaddr  (awaddr),
        .m_axi_awvalid (awvalid),
        .m_axi_awready (awready),
        .m_axi_wdata   (wdata),
        .m_axi_wstrb   (wstrb),
        .m_axi_wvalid  (wvalid),
        .m_axi_wready  (wready),
        .m_axi_bresp   (bresp),
        .m_axi_bvalid  (bvalid),
        .m_axi_bready  (bready),
        .m_axi_araddr  (araddr),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        cs = 1'b0; read_n = 1'b1; write_n = 1'b1;
        address = '0; writedata = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        #1;
        // ---------------- reset state ----------------
        chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
        chk("rst_wvalid",  {31'd0, wvalid},  32'd0);
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_bready",  {31'd0, bready},  32'd0);
        chk("rst_rready",  {31'd0, rready},  32'd0);
        chk("rst_awaddr",  {24'd0, awaddr},  32'd0);
        chk("rst_wdata",   wdata,            32'd0);
        chk("rst_readdata",{16'd0, readdata},32'd0);
        chk("rst_resp_err",{31'd0, resp_err},32'd0);
        chk("rst_waitreq", {31'd0, waitrequest}, 32'd0);
        rst_n = 1'b1;
        step();

        // ---------------- write, zero-wait slave ----------------
        // cycle 0 (IDLE): request presented
        cs = 1'b1; write_n = 1'b0; address = 5'h03; writedata = 16'hA55A;
        awready = 1'b1; wready = 1'b1;
        #1;
        chk("wr_c0_waitreq", {31'd0, waitrequest}, 32'd1);
        step();
        // cycle 1 (WR_REQ)
        #1;
        chk("wr_c1_awvalid", {31'd0, awvalid}, 32'd1);
        chk("wr_c1_wvalid",  {31'd0, wvalid},  32'd1);
        chk("wr_c1_awaddr",  {24'd0, awaddr},  32'h0000000C);
        chk("wr_c1_wdata",   wdata,            32'h0000A55A);
        chk("wr_c1_wstrb",   {28'd0, wstrb},   32'h3);
        chk("wr_c1_arvalid", {31'd0, arvalid}, 32'd0);
        chk("wr_c1_waitreq", {31'd0, waitrequest}, 32'd1);
        step();
        // cycle 2 (WR_RESP)
        bvalid = 1'b1; bresp = 2'b00;
        #1;
        chk("wr_c2_awvalid", {31'd0, awvalid}, 32'd0);
        chk("wr_c2_wvalid",  {31'd0, wvalid},  32'd0);
        chk("wr_c2_bready",  {31'd0, bready},  32'd1);
        chk("wr_c2_waitreq", {31'd0, waitrequest}, 32'd1);
        step();
        // cycle 3 (DONE)
        bvalid = 1'b0;
        #1;
        chk("wr_c3_waitreq", {31'd0, waitrequest}, 32'd0);
        chk("wr_c3_bready",  {31'd0, bready},  32'd0);
        chk("wr_c3_resp_err",{31'd0, resp_err},32'd0);
        idle_inputs();
        step();

        // ---------------- read with 5 rvalid stall cycles ----------------
        hi_cnt = 0;
        // cycle 0 (IDLE)
        cs = 1'b1; read_n = 1'b0; address = 5'h07; arready = 1'b1;
        #1;
        if (waitrequest) hi_cnt++;
        step();
        // cycle 1 (RD_REQ)
        #1;
        if (waitrequest) hi_cnt++;
        chk("rd_c1_arvalid", {31'd0, arvalid}, 32'd1);
        chk("rd_c1_araddr",  {24'd0, araddr},  32'h0000001C);
        chk("rd_c1_awvalid", {31'd0, awvalid}, 32'd0);
        step();
        // cycle 2 (RD_RESP, first stall)
        #1;
        if (waitrequest) hi_cnt++;
        chk("rd_c2_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rd_c2_rready",  {31'd0, rready},  32'd1);
        // cycles 3..6: remaining stalls
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            if (waitrequest) hi_cnt++;
        end
        chk("rd_c6_rready", {31'd0, rready}, 32'd1);
        step();
        // cycle 7: slave returns data
        rvalid = 1'b1; rdata = 32'hFFFF1234; rresp = 2'b00;
        #1;
        if (waitrequest) hi_cnt++;
        step();
        // cycle 8 (DONE)
        rvalid = 1'b0;
        #1;
        chk("rd_c8_waitreq",  {31'd0, waitrequest}, 32'd0);
        chk("rd_c8_readdata", {16'd0, readdata},    32'h00001234);
        chk("rd_c8_rready",   {31'd0, rready},      32'd0);
        chk("rd_wait_cycles", hi_cnt,               32'd8);
        idle_inputs();
        step();
        chk("rd_hold_readdata", {16'd0, readdata}, 32'h00001234);

        // ---------------- split write handshake ----------------
        // cycle 0 (IDLE)
        cs = 1'b1; write_n = 1'b0; address = 5'h01; writedata = 16'h0001;
        awready = 1'b1; wready = 1'b0;
        step();
        // cycle 1: AW handshakes at the end of this cycle, W does not
        #1;
        chk("sp_c1_awvalid", {31'd0, awvalid}, 32'd1);
        chk("sp_c1_wvalid",  {31'd0, wvalid},  32'd1);
        step();
        // cycle 2
        #1;
        chk("sp_c2_awvalid", {31'd0, awvalid}, 32'd0);
        chk("sp_c2_wvalid",  {31'd0, wvalid},  32'd1);
        chk("sp_c2_bready",  {31'd0, bready},  32'd0);
        step();
        // cycle 3
        #1;
        chk("sp_c3_wvalid", {31'd0, wvalid}, 32'd1);
        step();
        // cycle 4: W handshakes
        wready = 1'b1;
        #1;
        chk("sp_c4_wvalid", {31'd0, wvalid}, 32'd1);
        chk("sp_c4_bready", {31'd0, bready}, 32'd0);
        step();
        // cycle 5 (WR_RESP)
        wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        #1;
        chk("sp_c5_wvalid",  {31'd0, wvalid},  32'd0);
        chk("sp_c5_bready",  {31'd0, bready},  32'd1);
        chk("sp_c5_awvalid", {31'd0, awvalid}, 32'd0);
        step();
        // cycle 6 (DONE): exactly one B accepted
        #1;
        chk("sp_c6_waitreq", {31'd0, waitrequest}, 32'd0);
        chk("sp_c6_bready",  {31'd0, bready},      32'd0);
        idle_inputs();
        step();

        // ---------------- error write, then OKAY read ----------------
        cs = 1'b1; write_n = 1'b0; address = 5'h02; writedata = 16'h1111;
        awready = 1'b1; wready = 1'b1;
        step();   // WR_REQ
        step();   // WR_RESP
        bvalid = 1'b1; bresp = 2'b10;
        step();   // DONE
        bvalid = 1'b0;
        #1;
        chk("err_wr_waitreq",  {31'd0, waitrequest}, 32'd0);
        chk("err_wr_resp_err", {31'd0, resp_err},    32'd1);
        idle_inputs();
        step();
        cs = 1'b1; read_n = 1'b0; address = 5'h04; arready = 1'b1;
        step();   // RD_REQ
        step();   // RD_RESP
        rvalid = 1'b1; rdata = 32'h000000BE; rresp = 2'b00;
        step();   // DONE
        rvalid = 1'b0;
        #1;
        chk("ok_rd_resp_err", {31'd0, resp_err},    32'd0);
        chk("ok_rd_readdata", {16'd0, readdata},    32'h000000BE);
        idle_inputs();
        step();

        // ---------------- both strobes low: write wins ----------------
        cs = 1'b1; write_n = 1'b0; read_n = 1'b0; address = 5'h05; writedata = 16'hBEEF;
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        step();   // WR_REQ
        #1;
        chk("both_awvalid", {31'd0, awvalid}, 32'd1);
        chk("both_arvalid", {31'd0, arvalid}, 32'd0);
        chk("both_wdata",   wdata,            32'h0000BEEF);
        step();   // WR_RESP
        bvalid = 1'b1;
        #1;
        chk("both_arvalid2", {31'd0, arvalid}, 32'd0);
        step();   // DONE
        bvalid = 1'b0;
        #1;
        chk("both_waitreq", {31'd0, waitrequest}, 32'd0);
        idle_inputs();
        step();

        // ---------------- reset while arvalid high ----------------
        cs = 1'b1; read_n = 1'b0; address = 5'h09; arready = 1'b0;
        step();   // RD_REQ, slave stalls AR
        #1;
        chk("rr_arvalid_pre", {31'd0, arvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_arvalid",  {31'd0, arvalid},     32'd0);
        chk("rr_readdata", {16'd0, readdata},    32'd0);
        chk("rr_araddr",   {24'd0, araddr},      32'd0);
        // request still present, state back in IDLE -> stalled
        chk("rr_waitreq",  {31'd0, waitrequest}, 32'd1);
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
        // fresh read after release
        cs = 1'b1; read_n = 1'b0; address = 5'h1F; arready = 1'b1;
        step();   // RD_REQ
        #1;
        chk("rr2_araddr", {24'd0, araddr}, 32'h0000007C);
        step();   // RD_RESP
        rvalid = 1'b1; rdata = 32'h0000C0DE; rresp = 2'b00;
        step();   // DONE
        rvalid = 1'b0;
        #1;
        chk("rr2_waitreq",  {31'd0, waitrequest}, 32'd0);
        chk("rr2_readdata", {16'd0, readdata},    32'h0000C0DE);
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/avalon_axil_master.md
# avalon_axil_master

Bridge from the 16-bit Avalon-style CAN register bus (cs/read_n/write_n/address/writedata/readdata) to an AXI4-Lite master port. It is the inverse of our AXI4-Lite-slave-to-CAN bridge. A local engine that speaks the CAN register protocol can use it to reach any AXI4-Lite slave, including the CAN bridge itself, for loopback verification. Each accepted local request becomes one AXI4-Lite single transfer. The local side is stalled with `waitrequest` until the AXI response returns.

## Interface
- `AW`, 8: AXI address width; local word address maps to `{ {AW-7{0}}, address, 2'b00 }`.
- `m_axi_aclk`  in  1  sole clock, all logic rising-edge.
- `m_axi_aresetn`  in  1  asynchronous, active-low reset.
- `address`  in  5  local word address.
- `writedata`  in  16  local write data.
- `readdata`  out  16  read data, valid in the completion cycle, held until the next read completes.
- `cs`  in  1  chip select, high active.
- `read_n` / `write_n`  in  1 each  active-low request strobes.
- `waitrequest`  out  1  high while a request is in flight; the request is accepted in the cycle it is low.
- `resp_err`  out  1  high if the last completed transfer returned RESP≠OKAY; updated at each completion.
- `m_axi_awaddr` out AW; `m_axi_awvalid` out 1; `m_axi_awready` in 1.
- `m_axi_wdata` out 32 = `{16'd0, writedata}`; `m_axi_wstrb` out 4 = 4'b0011; `m_axi_wvalid` out 1; `m_axi_wready` in 1.
- `m_axi_bresp` in 2; `m_axi_bvalid` in 1; `m_axi_bready` out 1.
- `m_axi_araddr` out AW; `m_axi_arvalid` out 1; `m_axi_arready` in 1.
- `m_axi_rdata` in 32 (bits 15:0 used); `m_axi_rresp` in 2; `m_axi_rvalid` in 1; `m_axi_rready` out 1.

## Operation
- A request exists when `cs & ~write_n` (write) or `cs & ~read_n` (read). If both strobes are low, the write wins.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE: on a request, latch address and data, then go to WR_REQ or RD_REQ.
- WR_REQ: assert `awvalid` and `wvalid` together.
  - Each is dropped independently on its own handshake (flags `aw_done`, `w_done`).
  - When both are done, whether in the same or different cycles, go to WR_RESP.
- WR_RESP: `bready`=1. On `bvalid`, capture `resp_err = |bresp` and go to DONE.
- RD_REQ: `arvalid`=1 until `arready`, then go to RD_RESP.
- RD_RESP: `rready`=1. On `rvalid`, latch `readdata = rdata[15:0]` and `resp_err = |rresp`, then go to DONE.
- DONE: `waitrequest`=0 for exactly one cycle. The local master samples `readdata` here. Then go to IDLE.
- `waitrequest` = request present & state≠DONE. With no request it is 0.
- Valid signals are never withdrawn before their handshake. Address and data stay stable while valid is high.
- The bridge never has more than one transaction outstanding.
- Requests that drop during the FSM's traversal are not aborted; the AXI transfer completes anyway.
- If a request is still present in DONE, it is treated as accepted. A fresh request is sampled in IDLE on the following cycle.

## Timing
- All AXI outputs and `readdata`/`resp_err` are registered.
- Reset values: all valid/ready outputs 0, addresses 0, `wdata` 0, `readdata` 0x0000, `resp_err` 0, state IDLE. `waitrequest` follows its combinational rule.
- Write timeline with a zero-wait slave:
  - Request seen at edge 0.
  - awvalid/wvalid high in cycle 1.
  - Handshake at edge 2; bready high in cycle 2.
  - bvalid taken at edge 3; DONE in cycle 3.
  - Minimum latency is 4 cycles, request to acceptance.
- Read: the same four cycles (RD_REQ, RD_RESP, DONE).
- Slave stalls extend WR_REQ, RD_REQ, WR_RESP or RD_RESP indefinitely. There is no timeout.
- Asserting `m_axi_aresetn` mid-transfer forces every output to its reset value immediately. The AXI slave must be reset together with the bridge.

## Test plan
- Write: address=5'h03, writedata=16'hA55A, zero-wait slave -> awaddr=8'h0C, wdata=32'h0000A55A, wstrb=4'b0011; waitrequest low in cycle 3; resp_err=0.
- Read: address=5'h07, slave returns rdata=32'hFFFF1234 after 5 stall cycles on rvalid -> araddr=8'h1C; readdata=16'h1234 in DONE; waitrequest high for 8 cycles.
- Split write handshake: awready at cycle 1, wready at cycle 4 -> awvalid drops after cycle 1, wvalid stays high until cycle 4, bready asserts in cycle 5, one B accepted.
- Error response: bresp=2'b10 on a write -> resp_err=1. A following read with rresp=2'b00 -> resp_err=0.
- Simultaneous read_n=0 and write_n=0 -> only AW/W are issued, arvalid stays 0.
- Reset mid-operation: assert `m_axi_aresetn`=0 while arvalid is high -> arvalid=0 the same cycle, state IDLE, readdata=0. After release a new read completes normally.
